// File: rtl/alu_ctrl_pkg.sv
// ============================================================================
//  Module      : alu_ctrl_pkg
//  Description : Shared opcode/state types and width default for the
//                two-requester bitwise logic-unit controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_ctrl_pkg;

    localparam int c_WIDTH = 16;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_XNOR = 3'b011,
        OP_NAND = 3'b100,
        OP_NOR  = 3'b101,
        OP_NOTA = 3'b110,
        OP_PASB = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } ctrl_state_e;

endpackage

`default_nettype wire

// File: rtl/logic16_unit.sv
// ============================================================================
//  Module      : logic16_unit
//  Description : Purely combinational bitwise logic unit, op/a/b -> result.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module logic16_unit
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = c_WIDTH
) (
    input  alu_op_e          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_XNOR: result = ~(a ^ b);
            OP_NAND: result = ~(a & b);
            OP_NOR:  result = ~(a | b);
            OP_NOTA: result = ~a;
            OP_PASB: result = b;
            default: result = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_logic_arbiter.sv
// ============================================================================
//  Module      : alu_logic_arbiter
//  Description : Round-robin controller sharing one logic unit between two
//                requesters; optional zero flag under `ALU_FLAGS_EN`.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_logic_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = c_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
`ifdef ALU_FLAGS_EN
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero
`else
    output logic [WIDTH-1:0] rsp_data
`endif
);

    ctrl_state_e      r_state;
    ctrl_state_e      w_state_nxt;

    logic             r_last_grant;
    alu_op_e          r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_id;
    logic [WIDTH-1:0] r_rsp_data;
    logic             r_rsp_id;

    logic             w_grant_any;
    logic             w_grant_id;
    logic             w_accept;
    logic [WIDTH-1:0] w_result;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        w_grant_any = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            w_grant_id = ~r_last_grant;
        end else begin
            w_grant_id = req1_valid;
        end
    end

    assign w_accept = (r_state == ST_IDLE) && w_grant_any;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_grant_any) w_state_nxt = ST_EXEC;
            ST_EXEC: w_state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready)   w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!rst && w_accept) begin
            req0_ready = ~w_grant_id;
            req1_ready = w_grant_id;
        end
        rsp_valid = (r_state == ST_RESP);
    end

    logic16_unit #(
        .WIDTH (WIDTH)
    ) u_logic (
        .op     (r_op),
        .a      (r_a),
        .b      (r_b),
        .result (w_result)
    );

    // Operands are captured only at acceptance so later port changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_op         <= OP_AND;
            r_a          <= '0;
            r_b          <= '0;
            r_id         <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_id     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_last_grant <= w_grant_id;
                r_id         <= w_grant_id;
                r_op         <= w_grant_id ? alu_op_e'(req1_op) : alu_op_e'(req0_op);
                r_a          <= w_grant_id ? req1_a : req0_a;
                r_b          <= w_grant_id ? req1_b : req0_b;
            end
            if (r_state == ST_EXEC) begin
                r_rsp_data <= w_result;
                r_rsp_id   <= r_id;
            end
        end
    end

    assign rsp_data = r_rsp_data;
    assign rsp_id   = r_rsp_id;

`ifdef ALU_FLAGS_EN
    logic r_rsp_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_zero <= 1'b0;
        end else if (r_state == ST_EXEC) begin
            r_rsp_zero <= (w_result == '0);
        end
    end

    assign rsp_zero = r_rsp_zero;
`endif

endmodule

`default_nettype wire
